// File: rtl/seg_bin2dec_disp_pkg.sv
// Shared types and constants for the seven-segment binary/decimal display driver.
package seg_pkg;

  localparam int unsigned CNT_W = 5;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned SEG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEX  = 2'd1,
    ST_CONV = 2'd2
  } state_e;

  // Active-low segment byte: bit7=a .. bit1=g, bit0=dp (kept off)
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // Glyphs indexed by nibble value; entry 0 is the rightmost element
  localparam logic [15:0][SEG_W-1:0] SEG_GLYPH = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

  function automatic logic [SEG_W-1:0] seg_glyph(input logic [NIB_W-1:0] nib);
    return SEG_GLYPH[nib];
  endfunction

endpackage

// File: rtl/seg_bin2dec_disp_if.sv
// Value handshake plus rendered display bus between producer and display driver.
interface seg_bin2dec_disp_if #(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      in_bin;
  logic                  in_hex;
  logic                  busy;
  logic                  done;
  logic [DIGITS*8-1:0]   seg_bus;

  modport master (
    output in_valid, in_bin, in_hex,
    input  in_ready, busy, done, seg_bus
  );

  modport slave (
    input  in_valid, in_bin, in_hex,
    output in_ready, busy, done, seg_bus
  );
endinterface

// File: rtl/seg_bin2dec_disp_lut.sv
// Combinational nibble to seven-segment glyph decoder.
module seg7_hex_lut
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [SEG_W-1:0] seg_c
);

  // Table lookup of the active-low glyph
  assign seg_c = seg_glyph(nib);

endmodule

// File: rtl/seg_bin2dec_disp.sv
// Multi-digit seven-segment driver: hex nibble split or sequential double-dabble to BCD,
// optional leading-zero blanking, image held until the next accepted value.
module seg_bin2dec_disp
  import seg_pkg::*;
#(
  parameter int unsigned BIN_W    = 16,
  parameter int unsigned DIGITS   = 5,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_bin2dec_disp_if.slave     bus
);

  localparam int unsigned BCD_W = DIGITS * NIB_W;
  localparam int unsigned IMG_W = DIGITS * SEG_W;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [IMG_W-1:0]   seg_q, seg_d;

  logic               accept_c;
  logic [BCD_W-1:0]   bcd_adj_c;
  logic [BCD_W-1:0]   nib_src_c;
  logic [IMG_W-1:0]   glyph_c;
  logic [IMG_W-1:0]   image_c;
  logic               lz_seen_c;

  assign accept_c     = bus.in_valid & ready_q;
  assign bus.in_ready = ready_q;
  assign bus.busy     = ~ready_q;
  assign bus.done     = done_q;
  assign bus.seg_bus  = seg_q;

  // Double-dabble correction: add 3 to every BCD digit that is 5 or more
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[NIB_W*i +: NIB_W] >= 4'd5) begin
        bcd_adj_c[NIB_W*i +: NIB_W] = bcd_q[NIB_W*i +: NIB_W] + 4'd3;
      end
    end
  end

  // Digit values to render: raw nibbles in hex mode, finished BCD otherwise
  always_comb begin
    nib_src_c = bcd_q;
    if (state_q == ST_HEX) begin
      nib_src_c = BCD_W'(bin_q);
    end
  end

  // One glyph decoder per digit
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_lut
    seg7_hex_lut u_lut (
      .nib   (nib_src_c[NIB_W*g +: NIB_W]),
      .seg_c (glyph_c[SEG_W*g +: SEG_W])
    );
  end

  // Leading-zero mask: blank digits above the most significant nonzero one, never digit0
  always_comb begin
    image_c   = glyph_c;
    lz_seen_c = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (nib_src_c[NIB_W*i +: NIB_W] != 4'd0) begin
        lz_seen_c = 1'b1;
      end
      if ((BLANK_LZ != 0) && !lz_seen_c) begin
        image_c[SEG_W*i +: SEG_W] = SEG_BLANK;
      end
    end
  end

  // Next-state, datapath and output-register logic
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    seg_d   = seg_q;
    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept_c) begin
          bin_d   = bus.in_bin;
          bcd_d   = '0;
          cnt_d   = CNT_W'(BIN_W - 1);
          last_d  = 1'b0;
          ready_d = 1'b0;
          state_d = bus.in_hex ? ST_HEX : ST_CONV;
        end
      end
      ST_HEX: begin
        seg_d   = image_c;
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      ST_CONV: begin
        if (last_q) begin
          // BCD is final; publish it in one step so the display never flickers
          seg_d   = image_c;
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          bcd_d = {bcd_adj_c[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_d = {bin_q[BIN_W-2:0], 1'b0};
          if (cnt_q == '0) begin
            last_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion and blanks the display
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      seg_q   <= {DIGITS{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
    end
  end

endmodule

// File: tb/tb_seg_bin2dec_disp.sv
// Self-checking bench: two drivers (blanking on/off) share one stimulus stream.
module tb_seg_bin2dec_disp;

  localparam int unsigned BIN_W  = 16;
  localparam int unsigned DIGITS = 5;

  logic clk = 1'b0;
  logic rst;

  seg_bin2dec_disp_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) b0 ();
  seg_bin2dec_disp_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) b1 ();

  assign b1.in_valid = b0.in_valid;
  assign b1.in_bin   = b0.in_bin;
  assign b1.in_hex   = b0.in_hex;

  seg_bin2dec_disp #(.BIN_W(BIN_W), .DIGITS(DIGITS), .BLANK_LZ(1)) dut_lz (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  seg_bin2dec_disp #(.BIN_W(BIN_W), .DIGITS(DIGITS), .BLANK_LZ(0)) dut_all (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] glyph_t [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  // Reference image from plain arithmetic on the value
  function automatic logic [39:0] model(input logic [15:0] v, input bit hex, input bit blz);
    int d [5];
    int x;
    int msd;
    logic [39:0] r;
    x = int'(v);
    msd = 0;
    for (int i = 0; i < 5; i++) begin
      if (hex) begin
        d[i] = (x >> (4 * i)) & 15;
      end else begin
        d[i] = x % 10;
        x = x / 10;
      end
      if (d[i] != 0) msd = i;
    end
    for (int i = 0; i < 5; i++) begin
      r[8*i +: 8] = (blz && i > msd) ? 8'hFF : glyph_t[d[i]];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one value, wait for done, check latency, handshake and both images
  task automatic run_one(input logic [15:0] v, input bit hex, input string tag);
    int guard;
    int lat;
    int rdy_low;
    int exp_lat;
    bit got;
    bit flick;
    logic [39:0] prev0;
    logic [39:0] prev1;
    exp_lat = hex ? 1 : 17;
    @(negedge clk);
    b0.in_valid = 1'b1;
    b0.in_bin   = v;
    b0.in_hex   = hex;
    guard = 0;
    while (b0.in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_ready_wait"}, 64'(guard < 40), 64'd1);
    prev0 = b0.seg_bus;
    prev1 = b1.seg_bus;
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
    got = 1'b0;
    lat = 0;
    rdy_low = 0;
    flick = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (b0.done === 1'b1) begin
        got = 1'b1;
        lat = k;
      end else begin
        if (b0.in_ready === 1'b0) rdy_low++;
        if (b0.seg_bus !== prev0 || b1.seg_bus !== prev1) flick = 1'b1;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_ready_low_cycles"}, 64'(rdy_low), 64'(exp_lat - 1));
    chk({tag, "_no_flicker"}, 64'(flick), 64'd0);
    chk({tag, "_ready_at_done"}, 64'(b0.in_ready), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(b0.busy), 64'd0);
    chk({tag, "_done_all"}, 64'(b1.done), 64'd1);
    chk({tag, "_seg_lz"}, 64'(b0.seg_bus), 64'(model(v, hex, 1'b1)));
    chk({tag, "_seg_all"}, 64'(b1.seg_bus), 64'(model(v, hex, 1'b0)));
  endtask

  initial begin
    int guard;
    int pulses;
    bit bad;
    logic [15:0] rv;
    rst = 1'b0;
    b0.in_valid = 1'b0;
    b0.in_bin   = '0;
    b0.in_hex   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg_lz", 64'(b0.seg_bus), 64'hFF_FFFF_FFFF);
    chk("rst_seg_all", 64'(b1.seg_bus), 64'hFF_FFFF_FFFF);
    chk("rst_ready", 64'(b0.in_ready), 64'd1);
    chk("rst_done", 64'(b0.done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_seg", 64'(b0.seg_bus), 64'hFF_FFFF_FFFF);
    chk("idle_ready", 64'(b0.in_ready), 64'd1);
    chk("idle_done", 64'(b0.done), 64'd0);

    // Directed values
    run_one(16'd65535, 1'b0, "dec65535");
    chk("dec65535_lit", 64'(b0.seg_bus), 64'h41_4949_0D49);
    run_one(16'd7, 1'b0, "dec7");
    chk("dec7_lit_lz", 64'(b0.seg_bus), 64'hFF_FFFF_FF1F);
    chk("dec7_lit_all", 64'(b1.seg_bus), 64'h03_0303_031F);
    run_one(16'd0, 1'b0, "dec0");
    chk("dec0_lit_lz", 64'(b0.seg_bus), 64'hFF_FFFF_FF03);
    chk("dec0_lit_all", 64'(b1.seg_bus), 64'h03_0303_0303);
    run_one(16'hBEEF, 1'b1, "hexBEEF");
    chk("hexBEEF_lit", 64'(b0.seg_bus), 64'hFF_C161_6171);
    run_one(16'd10000, 1'b0, "dec10000");
    run_one(16'h000F, 1'b1, "hex000F");

    // Handshake: valid held high, second value accepted in the done cycle
    @(negedge clk);
    b0.in_valid = 1'b1;
    b0.in_bin   = 16'd100;
    b0.in_hex   = 1'b0;
    @(posedge clk);
    #1;
    b0.in_bin = 16'h00A0;
    b0.in_hex = 1'b1;
    guard = 0;
    pulses = 0;
    while (b0.done !== 1'b1 && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    pulses += (b0.done === 1'b1) ? 1 : 0;
    chk("hs_first_latency", 64'(guard), 64'd17);
    chk("hs_first_seg", 64'(b0.seg_bus), 64'hFF_FF9F_0303);
    @(posedge clk);
    #1;
    chk("hs_accept_in_done_cycle", 64'(b0.in_ready), 64'd0);
    chk("hs_done_single", 64'(b0.done), 64'd0);
    @(posedge clk);
    #1;
    pulses += (b0.done === 1'b1) ? 1 : 0;
    chk("hs_second_done", 64'(b0.done), 64'd1);
    chk("hs_final_seg", 64'(b0.seg_bus), 64'hFF_FFFF_1103);
    b0.in_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      pulses += (b0.done === 1'b1) ? 1 : 0;
    end
    chk("hs_pulse_count", 64'(pulses), 64'd2);

    // Reset mid-conversion
    @(negedge clk);
    b0.in_valid = 1'b1;
    b0.in_bin   = 16'd4321;
    b0.in_hex   = 1'b0;
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_seg_lz", 64'(b0.seg_bus), 64'hFF_FFFF_FFFF);
    chk("midrst_seg_all", 64'(b1.seg_bus), 64'hFF_FFFF_FFFF);
    chk("midrst_ready", 64'(b0.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (b0.done !== 1'b0 || b0.seg_bus !== 40'hFF_FFFF_FFFF) bad = 1'b1;
    end
    chk("midrst_no_done", 64'(bad), 64'd0);
    run_one(16'd4321, 1'b0, "after_rst");

    // Randomized values against the reference model
    for (int n = 0; n < 24; n++) begin
      rv = 16'($urandom);
      if (n % 4 == 0) rv = rv >> $urandom_range(4, 15);
      run_one(rv, bit'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
